// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// The result and borrow-out are registered and held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             bout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic a_bit;
  logic b_bit;
  logic d_next;
  logic br_next;

  // Full-subtractor cell on the bit selected by the counter
  always_comb begin
    a_bit   = a_reg[cnt_reg];
    b_bit   = b_reg[cnt_reg];
    d_next  = a_bit ^ b_bit ^ br_reg;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      diff_reg  <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            br_reg    <= bin;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Shift in from the top so bit 0 lands at the LSB after WIDTH steps
          res_reg <= {d_next, res_reg[WIDTH-1:1]};
          br_reg  <= br_next;
          if (cnt_reg == LAST) begin
            diff_reg  <= {d_next, res_reg[WIDTH-1:1]};
            bout_reg  <= br_next;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule
